gray_codec_pipe: RTL

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_pkg.sv | 19 +
 rtl/gray_conv.sv | 14 +
 rtl/gray_codec_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared mode constants, default sizes and Gray/binary conversion functions
package gray_pkg;
  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  // Functions work on 32-bit containers; bits at or above w are treated as zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b[31] = (w > 31) ? g[31] : 1'b0;
    for (int i = 30; i >= 0; i--) b[i] = (i < w) ? (b[i+1] ^ g[i]) : 1'b0;
    return b;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction
endpackage

// File: rtl/gray_conv.sv
// gray_conv: combinational Gray<->binary converter selected by mode
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [31:0] din_x;
  assign din_x = 32'(din);
  assign dout = WIDTH'((mode == MODE_B2G) ? bin2gray(din_x, WIDTH) : gray2bin(din_x, WIDTH));
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage Gray codec with sequence-error flagging and saturating error count
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, out_data_q, out_data_d;
  logic             s1_mode_q, s1_mode_d, out_mode_q, out_mode_d;
  logic             s1_err_q, s1_err_d, out_err_q, out_err_d;
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic             have_last_q, have_last_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] conv_out;
  logic             s1_adv, s2_adv, acc, acc_g2b, s2_load, seq_err;
  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .mode(s1_mode_q),
    .din (s1_data_q),
    .dout(conv_out)
  );
  always_comb begin
    s2_adv      = !s2_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    acc         = in_valid && s1_adv;
    acc_g2b     = acc && (in_mode == MODE_G2B);
    s2_load     = s2_adv && s1_valid_q;
    // A repeated word (distance 0) counts as a sequence error, as does any jump > 1.
    seq_err     = (in_mode == MODE_G2B) && have_last_q && ($countones(in_data ^ last_gray_q) != 1);
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_data_d   = acc ? in_data : s1_data_q;
    s1_mode_d   = acc ? in_mode : s1_mode_q;
    s1_err_d    = acc ? seq_err : s1_err_q;
    last_gray_d = acc_g2b ? in_data : last_gray_q;
    have_last_d = acc_g2b || have_last_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    out_data_d  = s2_load ? conv_out : out_data_q;
    out_mode_d  = s2_load ? s1_mode_q : out_mode_q;
    out_err_d   = s2_load ? s1_err_q : out_err_q;
    err_count_d = (s2_valid_q && out_ready && out_err_q && (err_count_q != '1)) ?
                  err_count_q + CNT_W'(1) : err_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
      last_gray_q <= '0;
      have_last_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
      last_gray_q <= last_gray_d;
      have_last_q <= have_last_d;
      err_count_q <= err_count_d;
    end
  end
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;
endmodule
